tmds_encoder_multi: RTL and testbench

//   Parametrised successor to the fixed 3-channel DVI TMDS encoder. Encodes NumChannels 8-bit

---
 rtl/tmds_encoder_multi_pkg.sv | 58 +++++
 rtl/tmds_encoder_multi_if.sv | 23 ++
 rtl/tmds_encoder_multi_lane_enc.sv | 59 +++++
 rtl/tmds_encoder_multi.sv | 73 +++++++
 tb/tb_tmds_encoder_multi.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/tmds_encoder_multi_pkg.sv
// Shared constants and helpers for the multi-lane TMDS encoder.
// Covers the control tokens, the 8b->9b transition-minimising encode and the colour-bar LUT.
package tmds_encoder_multi_pkg;

  localparam logic [9:0] TokCtl00 = 10'b1101010100;
  localparam logic [9:0] TokCtl01 = 10'b0010101011;
  localparam logic [9:0] TokCtl10 = 10'b0101010100;
  localparam logic [9:0] TokCtl11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  // q_m[8] records which chain was used: 1 = XOR, 0 = XNOR.
  function automatic logic [8:0] encode_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TokCtl00;
      2'b01:   t = TokCtl01;
      2'b10:   t = TokCtl10;
      default: t = TokCtl11;
    endcase
    return t;
  endfunction

  // Packed as {R,G,B}, which lines up with lanes {2,1,0}.
  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    logic [23:0] c;
    case (bar)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tmds_encoder_multi_if.sv
// Pixel-side bundle of the TMDS encoder: RGB/DE/sync in, TMDS symbols and aligned DE out.
interface tmds_encoder_multi_if #(
  parameter int NumChannels = 3
);
  logic [8*NumChannels-1:0]     data_i;
  logic                         de_i;
  logic                         hsync_i;
  logic                         vsync_i;
  logic [2*(NumChannels-1)-1:0] ctl_i;
  logic                         tp_en_i;
  logic [10*NumChannels-1:0]    tmds_o;
  logic                         de_o;

  modport master (
    output data_i, de_i, hsync_i, vsync_i, ctl_i, tp_en_i,
    input  tmds_o, de_o
  );

  modport slave (
    input  data_i, de_i, hsync_i, vsync_i, ctl_i, tp_en_i,
    output tmds_o, de_o
  );
endinterface

// File: rtl/tmds_encoder_multi_lane_enc.sv
// One TMDS lane: stage-1 q_m register followed by stage-2 DC-balancing with running disparity.
module tmds_lane_enc
  import tmds_encoder_multi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] pix,
  input  logic       de_s1,
  input  logic [1:0] ctl_s1,
  output logic [9:0] tmds
);

  logic [8:0]        q_m;
  logic [3:0]        n1;
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_next;
  logic signed [4:0] diff;
  logic signed [4:0] bonus;
  logic signed [4:0] penalty;
  logic [9:0]        sym_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_m <= '0;
    else         q_m <= encode_qm(pix);
  end

  // diff = N1 - N0 of q_m[7:0]; modulo-32 wrap is harmless since cnt stays in -8..+8.
  always_comb begin
    n1       = popcount8(q_m[7:0]);
    diff     = $signed({n1, 1'b0}) - 5'sd8;
    bonus    = q_m[8] ? 5'sd2 : 5'sd0;
    penalty  = q_m[8] ? 5'sd0 : 5'sd2;
    sym_next = ctl_token(ctl_s1);
    cnt_next = '0;
    if (de_s1) begin
      if ((cnt == 5'sd0) || (n1 == 4'd4)) begin
        sym_next = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
        cnt_next = q_m[8] ? (cnt + diff) : (cnt - diff);
      end else if (((cnt > 5'sd0) && (n1 > 4'd4)) || ((cnt < 5'sd0) && (n1 < 4'd4))) begin
        sym_next = {1'b1, q_m[8], ~q_m[7:0]};
        cnt_next = cnt + bonus - diff;
      end else begin
        sym_next = {1'b0, q_m[8], q_m[7:0]};
        cnt_next = cnt - penalty + diff;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmds <= TokCtl00;
      cnt  <= '0;
    end else begin
      tmds <= sym_next;
      cnt  <= cnt_next;
    end
  end

endmodule

// File: rtl/tmds_encoder_multi.sv
// NumChannels-lane TMDS encoder with a fixed 2-cycle pipeline and optional colour-bar source.
module tmds_encoder_multi
  import tmds_encoder_multi_pkg::*;
#(
  parameter int NumChannels = 3,
  parameter int ActiveWidth = 1280,
  parameter int TestPattern = 1
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  tmds_encoder_multi_if.slave bus
);

  if (TestPattern == 1 && (NumChannels != 3 || ActiveWidth < 8)) begin : g_bad_cfg
    $error("tmds_encoder_multi: TestPattern needs NumChannels==3 and ActiveWidth>=8");
  end

  logic [8*NumChannels-1:0]  src;
  logic                      de_s1;
  logic                      de_s2;
  logic [2*NumChannels-1:0]  ctl_s1;
  logic [10*NumChannels-1:0] tmds_all;

  if (TestPattern == 1) begin : g_tp
    localparam int BarWidth = ActiveWidth / 8;
    localparam int PixW     = $clog2(ActiveWidth + 1);

    logic [PixW-1:0] pix_cnt;
    logic [PixW-1:0] bar_idx;
    logic [2:0]      bar;

    // Counts regardless of tp_en_i; parks at ActiveWidth so overlong lines stay on the black bar.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                          pix_cnt <= '0;
      else if (!bus.de_i)                   pix_cnt <= '0;
      else if (pix_cnt < PixW'(ActiveWidth)) pix_cnt <= pix_cnt + PixW'(1);
    end

    assign bar_idx = pix_cnt / PixW'(BarWidth);
    assign bar     = (bar_idx > PixW'(7)) ? 3'd7 : bar_idx[2:0];
    assign src     = bus.tp_en_i ? bar_colour(bar) : bus.data_i;
  end else begin : g_no_tp
    assign src = bus.data_i;
  end

  // Lane 0 carries {vsync,hsync}; lanes 1.. take their pair from ctl_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      de_s1  <= 1'b0;
      de_s2  <= 1'b0;
      ctl_s1 <= '0;
    end else begin
      de_s1  <= bus.de_i;
      de_s2  <= de_s1;
      ctl_s1 <= {bus.ctl_i, bus.vsync_i, bus.hsync_i};
    end
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_lane
    tmds_lane_enc u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .pix    (src[8*c +: 8]),
      .de_s1  (de_s1),
      .ctl_s1 (ctl_s1[2*c +: 2]),
      .tmds   (tmds_all[10*c +: 10])
    );
  end

  assign bus.tmds_o = tmds_all;
  assign bus.de_o   = de_s2;

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Self-checking bench for tmds_encoder_multi: directed cases plus randomised traffic vs a DVI reference model.
module tb_tmds_encoder_multi;

  logic clk_i = 1'b0;
  logic rst_ni;

  always #5 clk_i = ~clk_i;

  tmds_encoder_multi_if #(.NumChannels(3)) bus ();

  tmds_encoder_multi #(
    .NumChannels (3),
    .ActiveWidth (64),
    .TestPattern (1)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    logic [29:0] tmds;
    logic        de;
    int          lit;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   disp[3];
  int   pc;

  logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [9:0]  toks[4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference lane encoder: q_m[i] is the parity of d[0..i], with odd bits flipped in XNOR mode.
  function automatic logic [9:0] modelLane(input int lane, input logic [7:0] d);
    int         n1, ones, bal, par;
    bit         inv;
    logic       b8;
    logic [7:0] q;
    logic [9:0] sym;
    n1  = $countones(d);
    inv = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    par = 0;
    for (int i = 0; i < 8; i++) begin
      par  = par ^ int'(d[i]);
      q[i] = 1'(par ^ (inv ? (i % 2) : 0));
    end
    b8   = inv ? 1'b0 : 1'b1;
    ones = $countones(q);
    bal  = 2 * ones - 8;
    if (disp[lane] == 0 || bal == 0) begin
      sym = b8 ? {2'b01, q} : {2'b10, ~q};
      disp[lane] += b8 ? bal : -bal;
    end else if ((disp[lane] > 0 && bal > 0) || (disp[lane] < 0 && bal < 0)) begin
      sym = {1'b1, b8, ~q};
      disp[lane] += 2 * int'(b8) - bal;
    end else begin
      sym = {1'b0, b8, q};
      disp[lane] += bal - 2 * (1 - int'(b8));
    end
    return sym;
  endfunction

  function automatic void resetModel();
    for (int c = 0; c < 3; c++) disp[c] = 0;
    pc = 0;
    exp_q.delete();
    exp_q.push_back('{tmds: {3{10'h354}}, de: 1'b0, lit: -1});
    exp_q.push_back('{tmds: {3{10'h354}}, de: 1'b0, lit: -1});
  endfunction

  task automatic checkPending();
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      for (int c = 0; c < 3; c++)
        checkOutput($sformatf("lane%0d", c), 32'(bus.tmds_o[10*c +: 10]), 32'(e.tmds[10*c +: 10]));
      checkOutput("de_o", 32'(bus.de_o), 32'(e.de));
      if (e.lit >= 0) checkOutput("lane0_golden", 32'(bus.tmds_o[9:0]), 32'(e.lit));
    end
  endtask

  // Called at a falling edge: checks the output owed from two cycles ago, then drives the next input.
  task automatic applyStimulus(input logic [23:0] d, input logic de, input logic [1:0] sync,
                               input logic [3:0] ctl, input logic tp, input int lit);
    exp_t        e;
    logic [23:0] s;
    int          b;
    checkPending();
    bus.data_i  = d;
    bus.de_i    = de;
    bus.hsync_i = sync[0];
    bus.vsync_i = sync[1];
    bus.ctl_i   = ctl;
    bus.tp_en_i = tp;
    b = (pc / 8 > 7) ? 7 : pc / 8;
    s = tp ? bars[b] : d;
    e.de  = de;
    e.lit = lit;
    if (de) begin
      for (int c = 0; c < 3; c++) e.tmds[10*c +: 10] = modelLane(c, s[8*c +: 8]);
      pc++;
    end else begin
      e.tmds[9:0]   = toks[sync];
      e.tmds[19:10] = toks[ctl[1:0]];
      e.tmds[29:20] = toks[ctl[3:2]];
      for (int c = 0; c < 3; c++) disp[c] = 0;
      pc = 0;
    end
    exp_q.push_back(e);
    @(negedge clk_i);
  endtask

  initial begin
    automatic int   total = 0;
    automatic int   len;
    automatic logic tp;

    rst_ni      = 1'b0;
    bus.data_i  = '0;
    bus.de_i    = 1'b0;
    bus.hsync_i = 1'b0;
    bus.vsync_i = 1'b0;
    bus.ctl_i   = '0;
    bus.tp_en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    for (int c = 0; c < 3; c++) checkOutput($sformatf("reset_lane%0d", c), 32'(bus.tmds_o[10*c +: 10]), 32'h354);
    checkOutput("reset_de_o", 32'(bus.de_o), 32'd0);
    rst_ni = 1'b1;
    resetModel();

    repeat (4) applyStimulus(24'h0, 1'b0, 2'b00, 4'h0, 1'b0, 32'h354);
    applyStimulus(24'h0, 1'b0, 2'b01, 4'h6, 1'b0, 32'h0AB);
    applyStimulus(24'h0, 1'b0, 2'b10, 4'h9, 1'b0, 32'h154);
    applyStimulus(24'h0, 1'b0, 2'b11, 4'hF, 1'b0, 32'h2AB);

    applyStimulus(24'h0, 1'b1, 2'b00, 4'h0, 1'b0, 32'h100);
    applyStimulus(24'h0, 1'b1, 2'b00, 4'h0, 1'b0, 32'h3FF);
    applyStimulus(24'h0, 1'b1, 2'b00, 4'h0, 1'b0, 32'h100);
    applyStimulus(24'h0, 1'b1, 2'b00, 4'h0, 1'b0, 32'h3FF);
    applyStimulus(24'h0, 1'b0, 2'b00, 4'h0, 1'b0, 32'h354);
    applyStimulus(24'hFFFFFF, 1'b1, 2'b00, 4'h0, 1'b0, 32'h200);
    applyStimulus(24'h0, 1'b0, 2'b00, 4'h0, 1'b0, 32'h354);
    applyStimulus(24'h0, 1'b1, 2'b00, 4'h0, 1'b0, 32'h100);
    applyStimulus(24'h0, 1'b0, 2'b00, 4'h0, 1'b0, -1);

    for (int i = 0; i < 80; i++) applyStimulus(24'($urandom), 1'b1, 2'b00, 4'h0, 1'b1, -1);
    applyStimulus(24'h0, 1'b0, 2'b00, 4'h0, 1'b1, -1);

    for (int i = 0; i < 20; i++) applyStimulus(24'($urandom), 1'b1, 2'b00, 4'h0, 1'b1, -1);
    rst_ni = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) checkOutput($sformatf("midrst_lane%0d", c), 32'(bus.tmds_o[10*c +: 10]), 32'h354);
    checkOutput("midrst_de_o", 32'(bus.de_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    resetModel();
    applyStimulus(24'($urandom), 1'b1, 2'b00, 4'h0, 1'b1, 32'h200);
    for (int i = 0; i < 15; i++) applyStimulus(24'($urandom), 1'b1, 2'b00, 4'h0, 1'b1, -1);

    while (total < 10000) begin
      len = $urandom_range(1, 90);
      tp  = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 19) == 0) tp = ~tp;
        applyStimulus(24'($urandom), 1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), tp, -1);
      end
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++)
        applyStimulus(24'($urandom), 1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), tp, -1);
      total += 90;
    end

    repeat (2) applyStimulus(24'h0, 1'b0, 2'b00, 4'h0, 1'b0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
